// File: rtl/inv_resp_checker.sv
// Clocked response checker for inverter cells: after each stimulus change and a settle window,
// verifies y == ~a and keeps pass/error counts. Optional glitch detection via INV_CHK_GLITCH_EN.
module inv_resp_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             y,
    output logic             busy,
    output logic             check_valid,
    output logic             check_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic             first_err_a,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]    RELOAD  = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t        state, state_nxt;
    logic          a_q;
    logic          a_cap, a_cap_nxt;
    logic [SW-1:0] settle_cnt, settle_cnt_nxt;
    logic          change;
    logic          sample;
    logic          fail;
    logic          glitch_hit;

    assign change = en && (a != a_q);
    assign busy   = (state == SETTLE);

    // Every change event (re)captures a and reloads the window, including one on the sample edge.
    always_comb begin
        state_nxt      = state;
        a_cap_nxt      = a_cap;
        settle_cnt_nxt = settle_cnt;
        sample         = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (change) begin
                        a_cap_nxt      = a;
                        settle_cnt_nxt = RELOAD;
                        state_nxt      = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        if (change) begin
                            a_cap_nxt      = a;
                            settle_cnt_nxt = RELOAD;
                        end else begin
                            settle_cnt_nxt = settle_cnt - SW'(1);
                        end
                    end else begin
                        sample = 1'b1;
                        if (change) begin
                            a_cap_nxt      = a;
                            settle_cnt_nxt = RELOAD;
                            state_nxt      = SETTLE;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef INV_CHK_GLITCH_EN
    logic       y_q;
    logic       tog_inc;
    logic [1:0] tog_cnt;
    logic [1:0] tog_total;

    assign tog_inc    = (y != y_q);
    assign tog_total  = tog_cnt + {1'b0, tog_inc};
    assign glitch_hit = (tog_total > 2'd1);
    assign fail       = (y == a_cap) || glitch_hit;

    // Toggle count only needs to distinguish 0, 1 and "more than one".
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q        <= 1'b0;
            tog_cnt    <= 2'd0;
            glitch_cnt <= '0;
        end else begin
            y_q <= y;
            if (change) begin
                tog_cnt <= 2'd0;
            end else if (state == SETTLE && tog_inc && tog_cnt != 2'd2) begin
                tog_cnt <= tog_cnt + 2'd1;
            end
            if (sample && glitch_hit && glitch_cnt != CNT_MAX) begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end
        end
    end
`else
    assign glitch_hit = 1'b0;
    assign fail       = (y == a_cap);
    assign glitch_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= 1'b0;
            a_cap       <= 1'b0;
            settle_cnt  <= '0;
            check_valid <= 1'b0;
            check_pass  <= 1'b0;
            pass_cnt    <= '0;
            err_cnt     <= '0;
            err_flag    <= 1'b0;
            first_err_a <= 1'b0;
        end else begin
            state       <= state_nxt;
            a_q         <= a;
            a_cap       <= a_cap_nxt;
            settle_cnt  <= settle_cnt_nxt;
            check_valid <= sample;
            if (sample) begin
                check_pass <= !fail;
                if (fail) begin
                    if (err_cnt != CNT_MAX) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    err_flag <= 1'b1;
                    if (!err_flag) begin
                        first_err_a <= a_cap;
                    end
                end else if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_resp_checker.sv
// Scoreboard bench for inv_resp_checker: stimulus pushes hand-computed expectations,
// monitors pop and compare on each check_valid pulse.
module tb_inv_resp_checker;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        a   = 1'b0;
    logic        y;
    logic        y_ideal = 1'b1;
    logic        y_mode  = 1'b0;
    logic        y_force = 1'b1;
    logic        busy, check_valid, check_pass, err_flag, first_err_a;
    logic [15:0] pass_cnt, err_cnt, glitch_cnt;

    logic        a2 = 1'b0;
    logic        y2 = 1'b1;
    logic        busy2, check_valid2, check_pass2, err_flag2, first_err_a2;
    logic [1:0]  pass_cnt2, err_cnt2, glitch_cnt2;

    int          cyc = 0;
    int          drive_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        bit          pass;
        logic [15:0] pcnt;
        logic [15:0] ecnt;
        logic [15:0] gcnt;
        bit          flag;
        bit          fea;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [1:0]  sb2[$];
    logic [1:0]  mon_p2;

    logic [15:0] m_pass = '0, m_err = '0, m_glitch = '0;
    bit          m_flag = 1'b0, m_fea = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal inverter DUT: y is ~a registered one clock; y_mode swaps in a forced value.
    always @(posedge clk) y_ideal <= ~a;
    always @(posedge clk) y2 <= ~a2;
    assign y = y_mode ? y_force : y_ideal;

    inv_resp_checker #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .y(y),
        .busy(busy), .check_valid(check_valid), .check_pass(check_pass),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
        .first_err_a(first_err_a), .glitch_cnt(glitch_cnt)
    );

    inv_resp_checker #(.SETTLE_CYCLES(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .a(a2), .y(y2),
        .busy(busy2), .check_valid(check_valid2), .check_pass(check_pass2),
        .pass_cnt(pass_cnt2), .err_cnt(err_cnt2), .err_flag(err_flag2),
        .first_err_a(first_err_a2), .glitch_cnt(glitch_cnt2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic new_a);
        @(negedge clk);
        a = new_a;
        drive_cyc = cyc;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushExpect(input bit ok, input bit glitched, input bit acap);
        exp_t e;
        if (ok) begin
            if (m_pass != 16'hFFFF) m_pass++;
        end else begin
            if (m_err != 16'hFFFF) m_err++;
            if (!m_flag) m_fea = acap;
            m_flag = 1'b1;
        end
        if (glitched && m_glitch != 16'hFFFF) m_glitch++;
        e.pass = ok;
        e.pcnt = m_pass;
        e.ecnt = m_err;
        e.gcnt = m_glitch;
        e.flag = m_flag;
        e.fea  = m_fea;
        e.cyc  = drive_cyc + SETTLE + 1;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (check_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse actual=check_valid at cycle %0d required=no pulse", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("pulse_cycle", cyc, mon_e.cyc);
                checkOutput("check_pass", check_pass, mon_e.pass);
                checkOutput("pass_cnt", pass_cnt, mon_e.pcnt);
                checkOutput("err_cnt", err_cnt, mon_e.ecnt);
                checkOutput("glitch_cnt", glitch_cnt, mon_e.gcnt);
                checkOutput("err_flag", err_flag, mon_e.flag);
                checkOutput("first_err_a", first_err_a, mon_e.fea);
            end
        end
    end

    always @(negedge clk) begin
        if (check_valid2) begin
            if (sb2.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse_sat actual=check_valid2 at cycle %0d required=no pulse", cyc);
            end else begin
                mon_p2 = sb2.pop_front();
                checkOutput("sat_check_pass", check_pass2, 1);
                checkOutput("sat_pass_cnt", pass_cnt2, mon_p2);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=still running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        waitCycles(3);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_check_valid", check_valid, 0);
        checkOutput("rst_check_pass", check_pass, 0);
        checkOutput("rst_pass_cnt", pass_cnt, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_err_flag", err_flag, 0);
        checkOutput("rst_first_err_a", first_err_a, 0);
        checkOutput("rst_glitch_cnt", glitch_cnt, 0);
        rst = 1'b0;
        waitCycles(2);

        // Basic pass
        applyStimulus(1);
        pushExpect(1, 0, 1);
        waitCycles(2);
        checkOutput("busy_window", busy, 1);
        waitCycles(6);
        checkOutput("busy_idle", busy, 0);
        applyStimulus(0);
        pushExpect(1, 0, 0);
        waitCycles(8);

        // Stuck-at-1 output: a=1 fails, a=0 passes
        y_force = 1'b1;
        y_mode  = 1'b1;
        applyStimulus(1);
        pushExpect(0, 0, 1);
        waitCycles(10);
        applyStimulus(0);
        pushExpect(1, 0, 0);
        waitCycles(8);
        y_mode = 1'b0;

        // Restart window: toggles every 2 cycles, only the last one is checked
        applyStimulus(1);
        waitCycles(1);
        applyStimulus(0);
        waitCycles(1);
        applyStimulus(1);
        waitCycles(1);
        applyStimulus(0);
        pushExpect(1, 0, 0);
        waitCycles(8);

        // Change coincident with the sample edge
        applyStimulus(1);
        pushExpect(1, 0, 1);
        waitCycles(3);
        applyStimulus(0);
        pushExpect(1, 0, 0);
        waitCycles(1);
        checkOutput("busy_reenter", busy, 1);
        waitCycles(8);

        // Enable dropped mid-window, then toggling while disabled
        applyStimulus(1);
        waitCycles(2);
        en = 1'b0;
        waitCycles(1);
        checkOutput("en_drop_busy", busy, 0);
        applyStimulus(0);
        waitCycles(1);
        applyStimulus(1);
        waitCycles(1);
        checkOutput("en_off_busy", busy, 0);
        applyStimulus(0);
        waitCycles(2);
        en = 1'b1;
        waitCycles(6);
        checkOutput("en_off_pass_cnt", pass_cnt, m_pass);
        checkOutput("en_off_err_cnt", err_cnt, m_err);

        // Reset during SETTLE discards the check and clears counters
        applyStimulus(1);
        waitCycles(2);
        rst = 1'b1;
        a   = 1'b0;
        waitCycles(3);
        m_pass = '0; m_err = '0; m_glitch = '0; m_flag = 1'b0; m_fea = 1'b0;
        checkOutput("midrst_pass_cnt", pass_cnt, 0);
        checkOutput("midrst_err_cnt", err_cnt, 0);
        checkOutput("midrst_err_flag", err_flag, 0);
        checkOutput("midrst_busy", busy, 0);
        rst = 1'b0;
        waitCycles(8);

        // Glitch: y toggles three times inside the window and ends correct
        y_force = 1'b1;
        y_mode  = 1'b1;
        applyStimulus(1);
`ifdef INV_CHK_GLITCH_EN
        pushExpect(0, 1, 1);
`else
        pushExpect(1, 0, 1);
`endif
        waitCycles(1);
        y_force = 1'b0;
        waitCycles(1);
        y_force = 1'b1;
        waitCycles(1);
        y_force = 1'b0;
        waitCycles(8);
        y_mode = 1'b0;
        checkOutput("glitch_cnt_final", glitch_cnt, m_glitch);

        // Saturation on the CNT_W=2, SETTLE_CYCLES=1 instance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a2 = ~a2;
            sb2.push_back((i >= 2) ? 2'd3 : 2'(i + 1));
            waitCycles(2);
        end
        waitCycles(3);
        checkOutput("sat_err_cnt", err_cnt2, 0);
        checkOutput("sat_pass_final", pass_cnt2, 3);

        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("sb2_empty", sb2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
